// File: rtl/exc_trap_ctrl.sv
// Exception/interrupt trap controller: prioritises commit-time events, latches
// mcause/mepc/mtval, then flushes the pipeline and offers a redirect to fetch.
module exc_trap_ctrl #(
    parameter int unsigned     XLEN          = 32,
    parameter int unsigned     NUM_IRQ       = 4,
    parameter int unsigned     IRQ_CODE_BASE = 16,
    parameter logic [XLEN-1:0] PC_BASE       = 32'h0,
    parameter logic [XLEN-1:0] PC_LIMIT      = 32'hFFFF,
    parameter logic [XLEN-1:0] MEM_BASE      = 32'h1_0000,
    parameter logic [XLEN-1:0] MEM_LIMIT     = 32'h1_FFFF,
    parameter int unsigned     CNT_W         = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_i,
    input  logic [XLEN-1:0]    pc_i,
    input  logic               should_jump_i,
    input  logic [XLEN-1:0]    pc_jump_dst_i,
    input  logic               inst_invalid_i,
    input  logic               ecall_i,
    input  logic               ebreak_i,
    input  logic               mret_i,
    input  logic               mem_valid_i,
    input  logic               mem_store_i,
    input  logic [1:0]         mem_size_i,
    input  logic [XLEN-1:0]    data_addr_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] irq_en_i,
    input  logic               gie_i,
    input  logic [XLEN-1:0]    mtvec_i,
    output logic               stall_o,
    output logic               flush_o,
    output logic               redirect_valid_o,
    output logic [XLEN-1:0]    redirect_pc_o,
    input  logic               redirect_ready_i,
    output logic [XLEN-1:0]    mcause_o,
    output logic [XLEN-1:0]    mepc_o,
    output logic [XLEN-1:0]    mtval_o,
    output logic [CNT_W-1:0]   trap_count_o
);

    localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

    state_t             state;
    logic [XLEN-1:0]    pc_off;
    logic [XLEN-1:0]    addr_off;
    logic               pc_bad;
    logic               addr_bad;
    logic               misal;
    logic               jump_bad;
    logic [NUM_IRQ-1:0] pending;
    logic [IDX_W-1:0]   irq_idx;
    logic [XLEN-2:0]    irq_code;
    logic               sync_exc;
    logic               irq_take;
    logic               trap;
    logic               event_any;
    logic [XLEN-1:0]    cause;
    logic [XLEN-1:0]    tval;
    logic [XLEN-1:0]    vec_base;
    logic [XLEN-1:0]    target;

    // Event decode and priority selection; offsets avoid constant compares when a base is 0.
    always_comb begin
        pc_off   = pc_i - PC_BASE;
        addr_off = data_addr_i - MEM_BASE;
        pc_bad   = pc_off > (PC_LIMIT - PC_BASE);
        addr_bad = addr_off > (MEM_LIMIT - MEM_BASE);
        jump_bad = should_jump_i && (pc_jump_dst_i[1:0] != 2'b00);
        case (mem_size_i)
            2'd0:    misal = 1'b0;
            2'd1:    misal = data_addr_i[0];
            default: misal = |data_addr_i[1:0];
        endcase

        pending = irq_i & irq_en_i;
        irq_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) irq_idx = IDX_W'(i);
        end
        irq_code = (XLEN-1)'(IRQ_CODE_BASE) + (XLEN-1)'(irq_idx);

        sync_exc = 1'b1;
        cause    = '0;
        tval     = '0;
        if (jump_bad) begin
            cause = XLEN'(0);
            tval  = pc_jump_dst_i;
        end else if (pc_bad) begin
            cause = XLEN'(1);
            tval  = pc_i;
        end else if (inst_invalid_i) begin
            cause = XLEN'(2);
            tval  = pc_i;
        end else if (ebreak_i) begin
            cause = XLEN'(3);
            tval  = pc_i;
        end else if (ecall_i) begin
            cause = XLEN'(11);
        end else if (mem_valid_i && addr_bad) begin
            cause = mem_store_i ? XLEN'(7) : XLEN'(5);
            tval  = data_addr_i;
        end else if (mem_valid_i && misal) begin
            cause = mem_store_i ? XLEN'(6) : XLEN'(4);
            tval  = data_addr_i;
        end else begin
            sync_exc = 1'b0;
        end

        irq_take = !sync_exc && gie_i && (|pending);
        if (irq_take) begin
            cause = {1'b1, irq_code};
            tval  = '0;
        end

        trap      = sync_exc || irq_take;
        event_any = valid_i && (trap || mret_i);
        vec_base  = {mtvec_i[XLEN-1:2], 2'b00};
        target    = (irq_take && (mtvec_i[1:0] == 2'b01))
                    ? vec_base + (XLEN'(irq_code) << 2) : vec_base;
    end

    // Hold the pipeline while a sequence is in flight, and on the cycle one is detected.
    assign stall_o = !rst && ((state != IDLE) || event_any);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            flush_o          <= 1'b0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            mcause_o         <= '0;
            mepc_o           <= '0;
            mtval_o          <= '0;
            trap_count_o     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (event_any) begin
                        state   <= FLUSH;
                        flush_o <= 1'b1;
                        if (trap) begin
                            mcause_o      <= cause;
                            mtval_o       <= tval;
                            mepc_o        <= pc_i;
                            redirect_pc_o <= target;
                            if (trap_count_o != '1) trap_count_o <= trap_count_o + CNT_W'(1);
                        end else begin
                            redirect_pc_o <= mepc_o;
                        end
                    end
                end
                FLUSH: begin
                    flush_o          <= 1'b0;
                    redirect_valid_o <= 1'b1;
                    state            <= REDIRECT;
                end
                REDIRECT: begin
                    if (redirect_ready_i) begin
                        redirect_valid_o <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: begin
                    flush_o          <= 1'b0;
                    redirect_valid_o <= 1'b0;
                    state            <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_trap_ctrl.sv
// Scoreboard bench for exc_trap_ctrl: stimulus queues the expected trap record,
// a monitor compares it when the redirect is first offered.
module tb_exc_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, should_jump_i, inst_invalid_i, ecall_i, ebreak_i, mret_i;
    logic        mem_valid_i, mem_store_i, gie_i, redirect_ready_i;
    logic [1:0]  mem_size_i;
    logic [31:0] pc_i, pc_jump_dst_i, data_addr_i, mtvec_i;
    logic [3:0]  irq_i, irq_en_i;
    logic        stall_o, flush_o, redirect_valid_o;
    logic [31:0] redirect_pc_o, mcause_o, mepc_o, mtval_o;
    logic [1:0]  trap_count_o;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] tval;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    exc_trap_ctrl #(.CNT_W(2)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .pc_i(pc_i),
        .should_jump_i(should_jump_i), .pc_jump_dst_i(pc_jump_dst_i),
        .inst_invalid_i(inst_invalid_i), .ecall_i(ecall_i), .ebreak_i(ebreak_i),
        .mret_i(mret_i), .mem_valid_i(mem_valid_i), .mem_store_i(mem_store_i),
        .mem_size_i(mem_size_i), .data_addr_i(data_addr_i), .irq_i(irq_i),
        .irq_en_i(irq_en_i), .gie_i(gie_i), .mtvec_i(mtvec_i), .stall_o(stall_o),
        .flush_o(flush_o), .redirect_valid_o(redirect_valid_o),
        .redirect_pc_o(redirect_pc_o), .redirect_ready_i(redirect_ready_i),
        .mcause_o(mcause_o), .mepc_o(mepc_o), .mtval_o(mtval_o),
        .trap_count_o(trap_count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_events();
        valid_i = 0; should_jump_i = 0; pc_jump_dst_i = 0; inst_invalid_i = 0;
        ecall_i = 0; ebreak_i = 0; mret_i = 0; mem_valid_i = 0; mem_store_i = 0;
        mem_size_i = 0; data_addr_i = 0; irq_i = 0; pc_i = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall_o), 0);
        chk({tag, "_flush"}, 32'(flush_o), 0);
        chk({tag, "_rvalid"}, 32'(redirect_valid_o), 0);
        chk({tag, "_rpc"}, redirect_pc_o, 0);
        chk({tag, "_mcause"}, mcause_o, 0);
        chk({tag, "_mepc"}, mepc_o, 0);
        chk({tag, "_mtval"}, mtval_o, 0);
        chk({tag, "_count"}, 32'(trap_count_o), 0);
    endtask

    // Called just after a negedge with event inputs already driven.
    task automatic issue(input string name, input exp_t e);
        sb.push_back(e);
        #1 chk({name, "_stall_detect"}, 32'(stall_o), 1);
        @(posedge clk);
        #1 clear_events();
    endtask

    task automatic wait_done(input string name);
        int n;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (!stall_o && !redirect_valid_o) break;
        end
        if (n == 20) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: sequence still busy after 20 cycles", name);
        end
    endtask

    task automatic sync_vec(input string name, input logic [31:0] pc, input logic jmp,
                            input logic [31:0] jdst, input logic inv, input logic ebk,
                            input logic ecl, input logic memv, input logic st,
                            input logic [1:0] sz, input logic [31:0] addr,
                            input logic [31:0] ecause, input logic [31:0] etval);
        exp_t e;
        @(negedge clk);
        valid_i = 1; pc_i = pc; should_jump_i = jmp; pc_jump_dst_i = jdst;
        inst_invalid_i = inv; ebreak_i = ebk; ecall_i = ecl; mem_valid_i = memv;
        mem_store_i = st; mem_size_i = sz; data_addr_i = addr;
        e = '{pc: 32'h200, cause: ecause, epc: pc, tval: etval, cnt: 3};
        issue(name, e);
        wait_done(name);
    endtask

    // Monitor: compare queued expectation on the first cycle of each redirect offer.
    initial begin
        logic rv_prev;
        exp_t e;
        rv_prev = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rv_prev = 0;
            end else begin
                if (redirect_valid_o && !rv_prev) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_redirect: pc 0x%08h with empty scoreboard", redirect_pc_o);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_redirect_pc", redirect_pc_o, e.pc);
                        chk("sb_mcause", mcause_o, e.cause);
                        chk("sb_mepc", mepc_o, e.epc);
                        chk("sb_mtval", mtval_o, e.tval);
                        chk("sb_count", 32'(trap_count_o), e.cnt);
                        chk("sb_stall", 32'(stall_o), 1);
                    end
                end
                rv_prev = redirect_valid_o;
            end
        end
    end

    initial begin
        exp_t e;
        rst = 1; clear_events();
        irq_en_i = 0; gie_i = 0; mtvec_i = 32'h200; redirect_ready_i = 1;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 0;

        // Misaligned LW: flush for exactly one cycle, then redirect to mtvec base.
        @(negedge clk);
        valid_i = 1; pc_i = 32'h10; mem_valid_i = 1; mem_size_i = 2; data_addr_i = 32'h1_0002;
        e = '{pc: 32'h200, cause: 4, epc: 32'h10, tval: 32'h1_0002, cnt: 1};
        issue("lw_misal", e);
        @(negedge clk);
        chk("lw_flush_on", 32'(flush_o), 1);
        chk("lw_rvalid_early", 32'(redirect_valid_o), 0);
        @(negedge clk);
        chk("lw_flush_off", 32'(flush_o), 0);
        chk("lw_rvalid_on", 32'(redirect_valid_o), 1);
        wait_done("lw_misal");

        // Illegal instruction outranks ECALL.
        @(negedge clk);
        valid_i = 1; pc_i = 32'h40; inst_invalid_i = 1; ecall_i = 1;
        e = '{pc: 32'h200, cause: 2, epc: 32'h40, tval: 32'h40, cnt: 2};
        issue("inv_ecall", e);
        wait_done("inv_ecall");

        // Fetch stalls: redirect held stable, second event in the window dropped.
        mtvec_i = 32'h101; redirect_ready_i = 0;
        @(negedge clk);
        valid_i = 1; pc_i = 32'h84; ecall_i = 1;
        e = '{pc: 32'h100, cause: 11, epc: 32'h84, tval: 0, cnt: 3};
        issue("ecall_hold", e);
        repeat (2) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            chk("hold_rvalid", 32'(redirect_valid_o), 1);
            chk("hold_rpc", redirect_pc_o, 32'h100);
            chk("hold_stall", 32'(stall_o), 1);
            if (c == 1) begin
                valid_i = 1; pc_i = 32'h90; inst_invalid_i = 1;
                @(posedge clk);
                #1 clear_events();
            end
            @(negedge clk);
        end
        redirect_ready_i = 1;
        wait_done("ecall_hold");
        chk("hold_drop_mcause", mcause_o, 32'd11);
        chk("hold_drop_mepc", mepc_o, 32'h84);

        // Vectored interrupt, lowest pending line wins; counter saturated at 3.
        @(negedge clk);
        valid_i = 1; pc_i = 32'h80; irq_i = 4'b0110; irq_en_i = 4'b1111; gie_i = 1;
        e = '{pc: 32'h144, cause: 32'h8000_0011, epc: 32'h80, tval: 0, cnt: 3};
        issue("irq_vec", e);
        wait_done("irq_vec");
        gie_i = 0;

        // MRET returns to mepc without touching trap state.
        @(negedge clk);
        valid_i = 1; pc_i = 32'h300; mret_i = 1;
        e = '{pc: 32'h80, cause: 32'h8000_0011, epc: 32'h80, tval: 0, cnt: 3};
        issue("mret", e);
        wait_done("mret");

        // Further synchronous causes and priorities.
        mtvec_i = 32'h200;
        sync_vec("st_misal", 32'h10, 0, 0, 0, 0, 0, 1, 1, 1, 32'h1_0001, 6, 32'h1_0001);
        sync_vec("ld_range", 32'h10, 0, 0, 0, 0, 0, 1, 0, 0, 32'h2_0000, 5, 32'h2_0000);
        sync_vec("st_range", 32'h10, 0, 0, 0, 0, 0, 1, 1, 2, 32'h0_FFFC, 7, 32'h0_FFFC);
        sync_vec("jmp_misal", 32'h10, 1, 32'h102, 1, 0, 0, 0, 0, 0, 0, 0, 32'h102);
        sync_vec("pc_range", 32'h1_0000, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h1_0000);
        sync_vec("ebreak", 32'h14, 0, 0, 0, 1, 1, 0, 0, 0, 0, 3, 32'h14);

        // Non-events: aligned byte access, masked interrupt, no valid_i.
        @(negedge clk);
        valid_i = 1; pc_i = 32'h20; mem_valid_i = 1; mem_size_i = 0; data_addr_i = 32'h1_0003;
        irq_i = 4'b0001; irq_en_i = 4'b1111; gie_i = 0;
        #1 chk("noevent_stall", 32'(stall_o), 0);
        @(posedge clk);
        #1 clear_events(); valid_i = 0; ecall_i = 1;
        #1 chk("novalid_stall", 32'(stall_o), 0);
        @(negedge clk);
        chk("noevent_flush", 32'(flush_o), 0);
        clear_events();

        // Reset during FLUSH aborts the sequence.
        @(negedge clk);
        valid_i = 1; pc_i = 32'h24; ecall_i = 1;
        e = '{pc: 32'h200, cause: 11, epc: 32'h24, tval: 0, cnt: 3};
        issue("rst_mid", e);
        @(negedge clk);
        chk("rst_mid_flush", 32'(flush_o), 1);
        #1 rst = 1;
        #1 chk_all_zero("rst_mid");
        sb.delete();
        @(negedge clk);
        rst = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("post_rst_quiet", 32'({flush_o, redirect_valid_o}), 0);
        end

        chk("sb_empty", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
